// File: rtl/lab5_tap_feeder_if.sv
// lab5_tap_feeder_if: sample handshake, flush request and tap/strobe outputs of the tap feeder
interface lab5_tap_feeder_if #(parameter int W = 10);
  logic signed [W-1:0] in_sample;
  logic in_valid;
  logic in_ready;
  logic flush;
  logic signed [W-1:0] x1;
  logic signed [W-1:0] x2;
  logic signed [W-1:0] x3;
  logic taps_valid;
  logic y_valid;
  logic busy;
  modport master (output in_sample, in_valid, flush, input in_ready, x1, x2, x3, taps_valid, y_valid, busy);
  modport slave (input in_sample, in_valid, flush, output in_ready, x1, x2, x3, taps_valid, y_valid, busy);
endinterface

// File: rtl/lab5_tap_feeder.sv
// lab5_tap_feeder: 3-deep sample delay line feeding the lab 5 tap datapath, with flush and y_valid alignment
module lab5_tap_feeder #(
  parameter int DPATH_LAT = 2,
  parameter int W = 10
) (
  input logic clk,
  input logic reset,
  lab5_tap_feeder_if.slave bus
);
  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [1:0] fill_q, fill_d, fill_e;
  logic inj_q, inj_d, clr_q, clr_d, rdy_q, rdy_d, busy_q, busy_d, tv_q, tv_d;
  logic inj, acc, shift, go_flush;
  logic signed [W-1:0] x1_q, x2_q, x3_q, x1_d, x2_d, x3_d, x1_b, x2_b, x3_b;
  logic [DPATH_LAT:0] yv;
  // clr_q marks the cycle right after the last injection: the line is zeroed
  // at the next edge, but a sample accepted on that edge lands on the zeroed line
  // Injected zeros do not advance fill_cnt, so a partial line never completes by flushing
  always_comb begin
    fill_e = clr_q ? 2'd0 : fill_q;
    x1_b = clr_q ? '0 : x1_q;
    x2_b = clr_q ? '0 : x2_q;
    x3_b = clr_q ? '0 : x3_q;
    inj = state_q == FLUSH;
    acc = bus.in_valid && rdy_q;
    shift = acc || inj;
    x1_d = shift ? (inj ? '0 : bus.in_sample) : x1_b;
    x2_d = shift ? x1_b : x2_b;
    x3_d = shift ? x2_b : x3_b;
    tv_d = shift && fill_e >= 2'd2;
    fill_d = (acc && fill_e != 2'd3) ? fill_e + 2'd1 : fill_e;
    go_flush = bus.flush && !inj && (acc || fill_e != 2'd0);
    clr_d = inj && inj_q;
    inj_d = inj && !inj_q;
    state_d = inj ? (inj_q ? FILL : FLUSH) : go_flush ? FLUSH : (fill_d == 2'd3 ? RUN : FILL);
    busy_d = state_d == FLUSH;
    rdy_d = state_d != FLUSH;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      fill_q <= '0;
      inj_q <= 1'b0;
      clr_q <= 1'b0;
      rdy_q <= 1'b0;
      busy_q <= 1'b0;
      tv_q <= 1'b0;
      x1_q <= '0;
      x2_q <= '0;
      x3_q <= '0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      inj_q <= inj_d;
      clr_q <= clr_d;
      rdy_q <= rdy_d;
      busy_q <= busy_d;
      tv_q <= tv_d;
      x1_q <= x1_d;
      x2_q <= x2_d;
      x3_q <= x3_d;
    end
  end
  assign yv[0] = tv_q;
  for (genvar g = 0; g < DPATH_LAT; g++) begin : g_ypipe
    always_ff @(posedge clk or posedge reset) begin
      if (reset) yv[g+1] <= 1'b0;
      else yv[g+1] <= yv[g];
    end
  end
  assign bus.y_valid = yv[DPATH_LAT];
  assign bus.in_ready = rdy_q;
  assign bus.busy = busy_q;
  assign bus.taps_valid = tv_q;
  assign bus.x1 = x1_q;
  assign bus.x2 = x2_q;
  assign bus.x3 = x3_q;
endmodule
